vx_gpr_bank_sched: RTL



---
 rtl/vx_gpr_bank_sched_pkg.sv | 50 +++++
 rtl/vx_gpr_bank_sched_arb.sv | 42 ++++
 rtl/vx_gpr_bank_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vx_gpr_bank_sched_pkg.sv
// Shared definitions for the banked GPR read-port scheduler.
//   - Default configuration constants (DEF_*), plus the bank-select and
//     bank-address widths they imply (BANK_SEL_W, BANK_ADDR_W).
//   - gpr_req_t: one read request {wis, rid, tag} at the default widths.
//   - gpr_bank_map(): maps {wis, rid} to a bank index and a bank address.
//     It takes its widths as arguments, so any instance configuration can
//     use it.
package vx_gpr_bank_sched_pkg;

  localparam int DEF_NUM_REQS    = 4;
  localparam int DEF_NUM_BANKS   = 4;
  localparam int DEF_NUM_REGS    = 32;
  localparam int DEF_WIS_W       = 2;
  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_XLEN        = 32;
  localparam int DEF_TAG_W       = 2;

  localparam int NR_BITS     = $clog2(DEF_NUM_REGS);
  localparam int BANK_SEL_W  = $clog2(DEF_NUM_BANKS);
  localparam int BANK_ADDR_W = DEF_WIS_W + NR_BITS - BANK_SEL_W;
  localparam int GPR_WIS_PW  = (DEF_WIS_W > 0) ? DEF_WIS_W : 1;

  typedef struct packed {
    logic [GPR_WIS_PW-1:0] wis;
    logic [NR_BITS-1:0]    rid;
    logic [DEF_TAG_W-1:0]  tag;
  } gpr_req_t;

  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] addr;
  } gpr_map_t;

  // The low rid bits select the bank. The address is {wis, remaining rid bits}.
  // With wis_w == 0 the wis field is dropped. With sel_w == 0 every register
  // lives in bank 0.
  function automatic gpr_map_t gpr_bank_map(input logic [31:0] wis,
                                            input logic [31:0] rid,
                                            input int          wis_w,
                                            input int          nr_bits,
                                            input int          sel_w);
    gpr_map_t    m;
    logic [31:0] wis_m;
    wis_m  = (wis_w > 0) ? wis : 32'd0;
    m.bank = rid & ((32'd1 << sel_w) - 32'd1);
    m.addr = (wis_m << (nr_bits - sel_w)) | (rid >> sel_w);
    return m;
  endfunction

endpackage

// File: rtl/vx_gpr_bank_sched_arb.sv
// vx_rr_arbiter_sel: N-wide round-robin picker with a registered pointer.
//   clk, reset : clock and synchronous active-high reset (pointer -> 0)
//   req   [N]  : candidate requests
//   grant [N]  : one-hot winner; this is the first request at or after the
//                pointer, wrapping. It is zero when no request is present.
// After a grant the pointer moves to winner+1 (mod N). Otherwise it holds.
module vx_rr_arbiter_sel #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               win;

  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        win   = (int'(ptr_q) + k) % N;
      end
    end
    if (found) grant[win] = 1'b1;
    ptr_d = ptr_q;
    if (found) ptr_d = (win == N - 1) ? '0 : PTR_W'(win + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vx_gpr_bank_sched.sv
// vx_gpr_bank_sched: read-port scheduler for a banked GPR file.
// NUM_REQS operand collectors share NUM_BANKS single-read-port RAMs. Each
// RAM has a 1-cycle registered read. Each cycle every bank grants at most one
// requester, chosen round-robin among those that target it. The read data
// returns to the winner exactly one cycle later, with no backpressure.
//
// Handshake: req_ready[i] is a combinational grant. A request is consumed in
// any cycle where req_valid[i] && req_ready[i]. A requester may drop
// req_valid without being granted. rsp_valid[i] pulses for one cycle, one
// cycle after the grant. The collector must take the response in that cycle.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid/wis/rid/tag    per-requester read request (packed, lane i)
//   req_ready                per-requester grant
//   bank_rd_en/addr          per-bank read strobe and address
//   bank_rd_data             per-bank read data, valid the cycle after rd_en
//   rsp_valid/tag/data       per-requester response
//   wb_*                     GPR write snoop (only with VX_GPR_BYPASS_EN)
//
// Configuration macro: VX_GPR_BYPASS_EN. It forwards a same-cycle GPR write
// over the RAM's stale read-during-write data.
module vx_gpr_bank_sched
  import vx_gpr_bank_sched_pkg::*;
#(
  parameter int NUM_REQS    = DEF_NUM_REQS,
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int WIS_W       = DEF_WIS_W,
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int XLEN        = DEF_XLEN,
  parameter int TAG_W       = DEF_TAG_W
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_REQS-1:0]                                    req_valid,
  input  logic [NUM_REQS*((WIS_W > 0) ? WIS_W : 1)-1:0]          req_wis,
  input  logic [NUM_REQS*$clog2(NUM_REGS)-1:0]                   req_rid,
  input  logic [NUM_REQS*TAG_W-1:0]                              req_tag,
  output logic [NUM_REQS-1:0]                                    req_ready,
  output logic [NUM_BANKS-1:0]                                   bank_rd_en,
  output logic [NUM_BANKS*(WIS_W+$clog2(NUM_REGS)-$clog2(NUM_BANKS))-1:0] bank_rd_addr,
  input  logic [NUM_BANKS*NUM_THREADS*XLEN-1:0]                  bank_rd_data,
`ifdef VX_GPR_BYPASS_EN
  input  logic                                                   wb_valid,
  input  logic [((WIS_W > 0) ? WIS_W : 1)-1:0]                   wb_wis,
  input  logic [$clog2(NUM_REGS)-1:0]                            wb_rd,
  input  logic [NUM_THREADS-1:0]                                 wb_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]                            wb_data,
`endif
  output logic [NUM_REQS-1:0]                                    rsp_valid,
  output logic [NUM_REQS*TAG_W-1:0]                              rsp_tag,
  output logic [NUM_REQS*NUM_THREADS*XLEN-1:0]                   rsp_data
);

  localparam int NR_W   = $clog2(NUM_REGS);
  localparam int SEL_W  = $clog2(NUM_BANKS);
  localparam int ADDR_W = WIS_W + NR_W - SEL_W;
  localparam int WIS_PW = (WIS_W > 0) ? WIS_W : 1;
  localparam int BIDX_W = (SEL_W > 0) ? SEL_W : 1;
  localparam int DATA_W = NUM_THREADS * XLEN;

  // Decode each request to its bank and bank address.
  logic [BIDX_W-1:0] req_bank [NUM_REQS];
  logic [ADDR_W-1:0] req_addr [NUM_REQS];
  gpr_map_t          req_map;

  always_comb begin
    req_map = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      req_map = gpr_bank_map(32'(req_wis[i*WIS_PW +: WIS_PW]),
                             32'(req_rid[i*NR_W +: NR_W]),
                             WIS_W, NR_W, SEL_W);
      req_bank[i] = BIDX_W'(req_map.bank);
      req_addr[i] = ADDR_W'(req_map.addr);
    end
  end

  // One arbiter per bank. Its candidates are the valid requests that map to it.
  logic [NUM_REQS-1:0] cand  [NUM_BANKS];
  logic [NUM_REQS-1:0] grant [NUM_BANKS];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        cand[b][i] = req_valid[i] && (req_bank[i] == BIDX_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vx_rr_arbiter_sel #(.N(NUM_REQS)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (cand[b]),
      .grant (grant[b])
    );
  end

  // A requester targets exactly one bank, so it gets at most one grant.
  // Idle banks drive address 0 so the bus never carries X.
  always_comb begin
    req_ready    = '0;
    bank_rd_en   = '0;
    bank_rd_addr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_rd_en[b] = |grant[b];
      for (int i = 0; i < NUM_REQS; i++) begin
        if (grant[b][i]) begin
          req_ready[i]                    = 1'b1;
          bank_rd_addr[b*ADDR_W +: ADDR_W] = req_addr[i];
        end
      end
    end
  end

  // Response pipeline: remember which bank each grant came from, and its tag.
  logic [NUM_REQS-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NUM_REQS*TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [BIDX_W-1:0]         rsp_bank_q [NUM_REQS];
  logic [BIDX_W-1:0]         rsp_bank_d [NUM_REQS];

  always_comb begin
    rsp_valid_d = req_ready;
    rsp_tag_d   = rsp_tag_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_bank_d[i] = rsp_bank_q[i];
      if (req_ready[i]) begin
        rsp_tag_d[i*TAG_W +: TAG_W] = req_tag[i*TAG_W +: TAG_W];
        rsp_bank_d[i]               = req_bank[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_tag_q   <= '0;
      for (int i = 0; i < NUM_REQS; i++) rsp_bank_q[i] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      for (int i = 0; i < NUM_REQS; i++) rsp_bank_q[i] <= rsp_bank_d[i];
    end
  end

`ifdef VX_GPR_BYPASS_EN
  // The RAM returns the old value when a read and a write hit the same word
  // in the same cycle. Capture the write and patch the enabled threads in the
  // response.
  logic [NUM_REQS-1:0]    byp_hit_q, byp_hit_d;
  logic [NUM_THREADS-1:0] byp_mask_q, byp_mask_d;
  logic [DATA_W-1:0]      byp_data_q, byp_data_d;

  always_comb begin
    byp_mask_d = wb_tmask;
    byp_data_d = wb_data;
    for (int i = 0; i < NUM_REQS; i++) begin
      byp_hit_d[i] = req_ready[i] && wb_valid
                  && (wb_wis == req_wis[i*WIS_PW +: WIS_PW])
                  && (wb_rd == req_rid[i*NR_W +: NR_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_hit_q  <= '0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= byp_hit_d;
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
    end
  end
`endif

  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rsp_data[i*DATA_W +: DATA_W] = bank_rd_data[int'(rsp_bank_q[i])*DATA_W +: DATA_W];
`ifdef VX_GPR_BYPASS_EN
      for (int j = 0; j < NUM_THREADS; j++) begin
        if (byp_hit_q[i] && byp_mask_q[j]) begin
          rsp_data[i*DATA_W + j*XLEN +: XLEN] = byp_data_q[j*XLEN +: XLEN];
        end
      end
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tag   = rsp_tag_q;

endmodule
